bin_to_bcd_seq: RTL and testbench

Sequential double-dabble (shift-add-3) converter that takes the 32-bit result of the 3/5 multiples accumulator and produces packed BCD for the display stage. It sits directly downstream of the accumulator top level. It captures the binary word on a start pulse and runs one shift per clock. It presents the BCD result with a one-cycle done pulse. A busy flag mirrors the accumulator's own busy/st handshake.

---
 rtl/bin_to_bcd_seq.sv | 117 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble (shift-add-3) binary to packed BCD converter.
// One shift per clock; a conversion takes WIDTH cycles from the accepted
// start to the done pulse. The result register holds its value between
// completed conversions.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  st,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = 4 * DIGITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_q, bin_d;
    logic [SW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     bcd_q, bcd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Scratch after the add-3 correction; a digit never exceeds 12 here,
    // so each digit is adjusted independently with no carry between digits.
    logic [SW-1:0]     adj;
    // Scratch after the left shift that pulls in the binary MSB.
    logic [SW-1:0]     shifted;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            // Add 3 to any digit of 5 or more before it is doubled.
            always_comb begin
                adj[gi*4 +: 4] = scratch_q[gi*4 +: 4];
                if (scratch_q[gi*4 +: 4] >= 4'd5) begin
                    adj[gi*4 +: 4] = scratch_q[gi*4 +: 4] + 4'd3;
                end
            end
        end
    endgenerate

    assign shifted = {adj[SW-2:0], bin_q[WIDTH-1]};

    // Next-state and next-output computation for the converter FSM.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (st) begin
                    bin_d     = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                scratch_d = shifted;
                bin_d     = {bin_q[WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bcd  = bcd_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: expected BCD values are computed by a
// decimal-division model, queued when a start is driven and popped at done.
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic                 clk;
    logic                 rst_n;
    logic [WIDTH-1:0]     bin;
    logic                 st;
    logic [4*DIGITS-1:0]  bcd;
    logic                 busy;
    logic                 done;

    int checks = 0;
    int errors = 0;
    logic [4*DIGITS-1:0] exp_q[$];
    logic [4*DIGITS-1:0] last_bcd;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bin),
        .st    (st),
        .bcd   (bcd),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: repeated division by ten.
    function automatic logic [4*DIGITS-1:0] to_bcd(input longint unsigned v);
        logic [4*DIGITS-1:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive a one-cycle start pulse; optionally queue the expected result.
    task automatic start(input logic [WIDTH-1:0] v, input bit push);
        @(negedge clk);
        bin = v;
        st  = 1'b1;
        if (push) exp_q.push_back(to_bcd(longint'(v)));
        @(negedge clk);
        st = 1'b0;
        chk("accept_busy_done", {62'd0, busy, done}, 64'd2);
    endtask

    // Follow a conversion from the negedge after the accept edge to done.
    // At cycle chg the input word is changed and a stray start is pulsed.
    task automatic wait_done(input int chg);
        logic [4*DIGITS-1:0] e;
        for (int k = 1; k < WIDTH; k++) begin
            @(negedge clk);
            if (k == chg) begin
                bin = 32'd999;
                st  = 1'b1;
            end else if (k == chg + 1) begin
                st = 1'b0;
            end
            chk("running_busy_done", {62'd0, busy, done}, 64'd2);
        end
        @(negedge clk);
        chk("done_busy_done", {62'd0, busy, done}, 64'd1);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            chk("done_bcd", {24'd0, bcd}, {24'd0, e});
            last_bcd = e;
        end
    endtask

    task automatic idle_hold(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk(tag, {22'd0, busy, done, bcd}, {24'd0, last_bcd});
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        st       = 1'b0;
        bin      = '0;
        last_bcd = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {22'd0, busy, done, bcd}, 64'd0);
        rst_n = 1'b1;

        // Zero, typical, full-scale and digit-carry boundary values.
        start(32'd0, 1'b1);           wait_done(-5); idle_hold(1, "idle_after_done");
        start(32'd233168, 1'b1);      wait_done(-5); idle_hold(1, "idle_after_done");
        start(32'd4294967295, 1'b1);  wait_done(-5); idle_hold(1, "idle_after_done");
        start(32'd99, 1'b1);          wait_done(-5); idle_hold(1, "idle_after_done");
        start(32'd100, 1'b1);         wait_done(-5); idle_hold(1, "idle_after_done");

        // Input change plus stray start mid-conversion: no effect, not queued.
        start(32'd12345, 1'b1);
        wait_done(10);
        idle_hold(5, "hold_after_ignored_st");

        // Reset at cycle 15 of a conversion aborts it.
        start(32'd777, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_reset_state", {22'd0, busy, done, bcd}, 64'd0);
        rst_n    = 1'b1;
        last_bcd = '0;
        idle_hold(40, "no_done_after_abort");
        start(32'd777, 1'b1);
        wait_done(-5);
        idle_hold(1, "idle_after_done");

        // Start held high: back-to-back conversions every WIDTH+1 cycles.
        @(negedge clk);
        bin = 32'd5;
        st  = 1'b1;
        for (int n = 0; n < 3; n++) begin
            exp_q.push_back(to_bcd(64'd5));
            @(negedge clk);
            chk("held_st_accept", {62'd0, busy, done}, 64'd2);
            if (n == 2) st = 1'b0;
            wait_done(-5);
        end
        idle_hold(3, "idle_after_held_st");

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
